uart_cmd_responder: RTL and testbench

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

---
 rtl/uart_cmd_responder.sv | 195 +++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: full-duplex 8N1 UART that assembles two received bytes
// into a 16-bit command and transmits single-byte responses on request.
// Optional feature macro: CMD_TIMEOUT_EN -- when defined, a half-assembled
// command is dropped if the gap before the second byte reaches TIMEOUT_CYCLES.
module uart_cmd_responder #(
    parameter int          BAUD_CYCLES    = 2604,
    parameter logic [25:0] TIMEOUT_CYCLES = 26'd2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int            BW        = $clog2(BAUD_CYCLES);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CYCLES - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_CYCLES / 2);

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } asm_state_t;

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic          start_det;

    logic          rx_busy;
    logic [BW-1:0] rx_baud;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          byte_valid;

    asm_state_t    state;
    logic [7:0]    hi_byte;
`ifdef CMD_TIMEOUT_EN
    logic [25:0]   to_cnt;
`endif

    logic          tx_busy;
    logic [BW-1:0] tx_baud;
    logic [3:0]    tx_bit;
    logic [7:0]    tx_shift;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_det = !rx_busy && rx_prev && !rx_sync;

    // Receiver: mid-bit sampling; goes idle at the stop-bit sample so a
    // back-to-back start edge is never missed. A high start sample aborts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_busy    <= 1'b0;
            rx_baud    <= '0;
            rx_bit     <= 4'd0;
            rx_shift   <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (!rx_busy) begin
                if (start_det) begin
                    rx_busy <= 1'b1;
                    rx_baud <= '0;
                    rx_bit  <= 4'd0;
                end
            end else if (rx_baud == BAUD_HALF) begin
                if (rx_bit == 4'd0) begin
                    rx_busy <= !rx_sync;
                    rx_baud <= rx_sync ? '0 : rx_baud + 1'b1;
                end else if (rx_bit == 4'd9) begin
                    rx_busy    <= 1'b0;
                    rx_baud    <= '0;
                    rx_bit     <= 4'd0;
                    byte_valid <= rx_sync;
                end else begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    rx_baud  <= rx_baud + 1'b1;
                end
            end else if (rx_baud == BAUD_LAST) begin
                rx_baud <= '0;
                rx_bit  <= rx_bit + 4'd1;
            end else begin
                rx_baud <= rx_baud + 1'b1;
            end
        end
    end

    // Command assembly FSM; a load sets cmd_rdy and takes priority over a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= WAIT_HI;
            hi_byte <= 8'h00;
            cmd     <= 16'h0000;
            cmd_rdy <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            to_cnt  <= 26'd0;
`endif
        end else begin
            case (state)
                WAIT_HI: begin
                    if (byte_valid) begin
                        hi_byte <= rx_shift;
                        state   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (byte_valid) begin
                        cmd   <= {hi_byte, rx_shift};
                        state <= WAIT_HI;
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (!rx_busy && (to_cnt == TIMEOUT_CYCLES - 26'd1)) begin
                        hi_byte <= 8'h00;
                        state   <= WAIT_HI;
                    end
`endif
                end
                default: state <= WAIT_HI;
            endcase

            if ((state == WAIT_LO) && byte_valid) begin
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || ((state == WAIT_HI) && start_det)) begin
                cmd_rdy <= 1'b0;
            end

`ifdef CMD_TIMEOUT_EN
            // Idle-gap counter only advances in WAIT_LO with the receiver idle.
            if ((state == WAIT_LO) && !rx_busy && !byte_valid) begin
                to_cnt <= to_cnt + 26'd1;
            end else begin
                to_cnt <= 26'd0;
            end
`endif
        end
    end

    // Transmitter: start bit on the cycle after acceptance, then 8 data bits
    // LSB first and a stop bit, each BAUD_CYCLES long; busy requests are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_busy   <= 1'b0;
            tx_baud   <= '0;
            tx_bit    <= 4'd0;
            tx_shift  <= 8'h00;
            TX        <= 1'b1;
            resp_sent <= 1'b0;
        end else if (!tx_busy) begin
            if (send_resp) begin
                tx_busy   <= 1'b1;
                tx_shift  <= resp;
                tx_baud   <= '0;
                tx_bit    <= 4'd0;
                TX        <= 1'b0;
                resp_sent <= 1'b0;
            end
        end else if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy   <= 1'b0;
                tx_bit    <= 4'd0;
                TX        <= 1'b1;
                resp_sent <= 1'b1;
            end else if (tx_bit == 4'd8) begin
                tx_bit <= 4'd9;
                TX     <= 1'b1;
            end else begin
                tx_bit   <= tx_bit + 4'd1;
                TX       <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[7:1]};
            end
        end else begin
            tx_baud <= tx_baud + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder (short baud period for speed).
// Follows the CMD_TIMEOUT_EN macro to pick the expected timeout behaviour.
module tb_uart_cmd_responder;

    localparam int          B  = 16;
    localparam logic [25:0] TO = 26'd2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        clr = 1'b0;
    logic        send = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        tx;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        resp_sent;

    always #5 clk = ~clk;

    uart_cmd_responder #(.BAUD_CYCLES(B), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .RX(rx), .TX(tx), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr), .resp(resp), .send_resp(send), .resp_sent(resp_sent)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state
    logic        seen_reset = 1'b0;
    logic [15:0] m_cmd = 16'h0000;
    logic        m_rdy = 1'b0;
    logic [7:0]  m_hi = 8'h00;
    logic        m_lo = 1'b0;          // 1 = first byte held, waiting for second
    logic        m_tx_active = 1'b0;
    int          m_tx_start = 0;
    logic [9:0]  m_tx_frame = 10'h3FF;
    logic        rx_active = 1'b0;     // a frame is on the wire; receive outputs in flux

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model bookkeeping on each rising edge: reset, clears, accepted responses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            seen_reset  <= 1'b1;
            m_cmd       <= 16'h0000;
            m_rdy       <= 1'b0;
            m_lo        <= 1'b0;
            m_tx_active <= 1'b0;
        end else begin
            if (clr) m_rdy <= 1'b0;
            if (send && (!m_tx_active || (cyc + 1 - m_tx_start > 10 * B))) begin
                m_tx_active <= 1'b1;
                m_tx_start  <= cyc + 1;
                m_tx_frame  <= {1'b1, resp, 1'b0};
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (seen_reset) begin
            int  el;
            logic exp_tx;
            logic exp_rs;
            el = cyc - m_tx_start;
            exp_tx = (m_tx_active && el < 10 * B) ? m_tx_frame[el / B] : 1'b1;
            exp_rs = m_tx_active && (el >= 10 * B);
            check("tx_line", {15'd0, tx}, {15'd0, exp_tx});
            check("resp_sent", {15'd0, resp_sent}, {15'd0, exp_rs});
            if (!rx_active) begin
                check("cmd", cmd, m_cmd);
                check("cmd_rdy", {15'd0, cmd_rdy}, {15'd0, m_rdy});
            end
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full UART frame; optional bad stop bit; optional clear pulse aligned
    // with the cycle the DUT loads cmd (stop sample + one cycle).
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic clr_at_load);
        rx_active = 1'b1;
        drive(1'b0, B);
        for (int i = 0; i < 8; i++) drive(b[i], B);
        rx = stop_ok;
        repeat (B / 2 + 4) @(posedge clk);
        #1;
        clr = clr_at_load;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (B - B / 2 - 5) @(posedge clk);
        #1;
        rx = 1'b1;
        if (!m_lo) begin
            m_rdy = 1'b0;
            if (stop_ok) begin
                m_hi = b;
                m_lo = 1'b1;
            end
        end else if (stop_ok) begin
            m_cmd = {m_hi, b};
            m_rdy = 1'b1;
            m_lo  = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
        rx_active = 1'b0;
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        rx_active = 1'b1;
        drive(1'b0, B);
        for (int i = 0; i < nbits; i++) drive(b[i], B);
    endtask

    logic [9:0] a5_seq;

    initial begin
        a5_seq = 10'b1101001010;   // line order from index 0: 0,1,0,1,0,0,1,0,1,1
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", {15'd0, tx}, 16'h0001);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'h0000);
        check("rst_resp_sent", {15'd0, resp_sent}, 16'h0000);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Basic two-byte command and clear
        send_byte(8'h23, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        check("cmd_23ff", cmd, 16'h23FF);
        check("rdy_23ff", {15'd0, cmd_rdy}, 16'h0001);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("rdy_cleared", {15'd0, cmd_rdy}, 16'h0000);

        // Response A5 with a busy-time request that must be ignored
        resp = 8'hA5;
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        for (int c = 1; c <= 10 * B + 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 50) begin
                resp = 8'h3C;
                send = 1'b1;
            end
            if (c == 51) send = 1'b0;
            if ((c % B == B / 2) && (c / B < 10))
                check("tx_a5_bit", {15'd0, tx}, {15'd0, a5_seq[c / B]});
            if (c == 10 * B - 1) check("resp_sent_early", {15'd0, resp_sent}, 16'h0000);
            if (c == 10 * B) check("resp_sent_done", {15'd0, resp_sent}, 16'h0001);
        end
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        check("resp_sent_reclr", {15'd0, resp_sent}, 16'h0000);
        repeat (10 * B + 5) @(posedge clk);
        #1;

        // Framing error in the middle is discarded
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        check("ferr_rdy", {15'd0, cmd_rdy}, 16'h0000);
        check("ferr_cmd", cmd, 16'h23FF);
        send_byte(8'h00, 1'b1, 1'b0);
        check("ferr_cmd_after", cmd, 16'h0000);
        check("ferr_rdy_after", {15'd0, cmd_rdy}, 16'h0001);

        // Long gap after the first byte
        send_byte(8'h23, 1'b1, 1'b0);
        repeat (2500) @(posedge clk);
        #1;
`ifdef CMD_TIMEOUT_EN
        m_lo = 1'b0;
`endif
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
`ifdef CMD_TIMEOUT_EN
        check("timeout_cmd", cmd, 16'h1234);
`else
        check("gap_cmd", cmd, 16'h2312);
`endif

        // Reset in the middle of a receive and a transmit
        resp = 8'hA5;
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send_partial(8'h55, 4);
        rx = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_tx", {15'd0, tx}, 16'h0001);
        check("midrst_rdy", {15'd0, cmd_rdy}, 16'h0000);
        check("midrst_cmd", cmd, 16'h0000);
        rst_n = 1'b1;
        rx_active = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        check("post_rst_cmd", cmd, 16'h0002);

        // Load coinciding with a clear: set wins
        send_byte(8'hAB, 1'b1, 1'b0);
        send_byte(8'hCD, 1'b1, 1'b1);
        check("setwin_rdy", {15'd0, cmd_rdy}, 16'h0001);
        check("setwin_cmd", cmd, 16'hABCD);
        repeat (5) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
